// File: rtl/mojo_com_pkg.sv
// Shared types and width helpers for the SPI/register-file port arbiter.
package mojo_com_pkg;

  localparam int WORD_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  function automatic int addr_bits(input int space);
    return (space > 1) ? $clog2(space) : 1;
  endfunction

endpackage

// File: rtl/mojo_com_if.sv
// Bundle of the master-side request lines and the downstream register-file port.
interface mojo_com_if
  import mojo_com_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_SPACE = 256
);
  localparam int ADDR_SPACE_BITS = addr_bits(ADDR_SPACE);

  logic [NUM_REQ-1:0]                 req_txn;
  logic [NUM_REQ-1:0]                 req_new;
  logic [NUM_REQ-1:0]                 req_write;
  logic [NUM_REQ*ADDR_SPACE_BITS-1:0] req_addr;
  logic [NUM_REQ*WORD_SIZE-1:0]       req_wdata;
  logic [NUM_REQ-1:0]                 grant;
  logic [NUM_REQ-1:0]                 rd_valid;
  logic [NUM_REQ-1:0]                 abort;
  logic [WORD_SIZE-1:0]               rdata;
  logic [ADDR_SPACE_BITS-1:0]         reg_addr;
  logic                               write;
  logic                               new_req;
  logic [WORD_SIZE-1:0]               write_value;
  logic                               in_transaction;
  logic [WORD_SIZE-1:0]               read_value;

  modport slave (
    input  req_txn, req_new, req_write, req_addr, req_wdata, read_value,
    output grant, rd_valid, abort, rdata, reg_addr, write, new_req,
           write_value, in_transaction
  );

  modport master (
    output req_txn, req_new, req_write, req_addr, req_wdata, read_value,
    input  grant, rd_valid, abort, rdata, reg_addr, write, new_req,
           write_value, in_transaction
  );

endinterface

// File: rtl/mojo_com_arbiter_rr_picker.sv
// Combinational round-robin select: first requesting index strictly after i_last.
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic                       o_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_index
);
  localparam int IW = $clog2(NUM_REQ);

  int w_idx;

  // Scan farthest-first so the nearest eligible index after i_last wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_idx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(i_last) + k) % NUM_REQ;
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_index = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mojo_com_arbiter.sv
// Transaction-granular round-robin arbiter sharing one register-file port among NUM_REQ masters.
module mojo_com_arbiter
  import mojo_com_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_SPACE = 256,
  parameter int TIMEOUT    = 1024
) (
  input logic       clk,
  input logic       rst_n,
  mojo_com_if.slave bus
);
  localparam int ABITS = addr_bits(ADDR_SPACE);
  localparam int IW    = $clog2(NUM_REQ);
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACTIVE = ST_ACTIVE;
  localparam logic [1:0] S_GAP    = ST_GAP;

  logic [1:0]           r_state;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_last_owner;
  logic [NUM_REQ-1:0]   r_stale;
  logic [NUM_REQ-1:0]   r_abort;
  logic [CW-1:0]        r_cnt;
  logic                 r_new_req_p1;
  logic                 r_write_p1;
  logic [IW-1:0]        r_acc_idx_p1;
  logic [ABITS-1:0]     r_addr_p1;
  logic [WORD_SIZE-1:0] r_wdata_p1;
  logic [NUM_REQ-1:0]   r_rd_valid_p2;

  logic                 w_pick_vld;
  logic [IW-1:0]        w_pick_idx;
  logic [NUM_REQ-1:0]   w_eligible;
  logic                 w_active;
  logic                 w_own_txn;
  logic                 w_fwd;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign w_eligible = bus.req_txn & ~r_stale;
  assign w_active   = (r_state == S_ACTIVE);
  assign w_own_txn  = bus.req_txn[r_owner];
  assign w_fwd      = w_active & w_own_txn & bus.req_new[r_owner];

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req   (w_eligible),
    .i_last  (r_last_owner),
    .o_valid (w_pick_vld),
    .o_index (w_pick_idx)
  );

  // Stale bits persist only while the master keeps req_txn asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= IW'(NUM_REQ - 1);
      r_stale      <= '0;
      r_abort      <= '0;
      r_cnt        <= '0;
    end else begin
      r_abort <= '0;
      r_stale <= r_stale & bus.req_txn;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_state      <= S_ACTIVE;
            r_owner      <= w_pick_idx;
            r_last_owner <= w_pick_idx;
            r_cnt        <= '0;
          end
        end
        S_ACTIVE: begin
          if (!w_own_txn) begin
            r_state <= S_GAP;
          end else if (w_fwd) begin
            r_cnt <= '0;
          end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
            r_state <= S_GAP;
            r_abort <= onehot(r_owner);
            r_stale <= (r_stale & bus.req_txn) | onehot(r_owner);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // p1: forwarded access registered toward the register file.
  // p2: owner-tagged completion pulse, aligned with read_value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_new_req_p1  <= 1'b0;
      r_write_p1    <= 1'b0;
      r_acc_idx_p1  <= '0;
      r_addr_p1     <= '0;
      r_wdata_p1    <= '0;
      r_rd_valid_p2 <= '0;
    end else begin
      r_new_req_p1 <= w_fwd;
      r_write_p1   <= w_fwd & bus.req_write[r_owner];
      if (w_fwd) begin
        r_acc_idx_p1 <= r_owner;
        r_addr_p1    <= bus.req_addr[int'(r_owner)*ABITS +: ABITS];
        r_wdata_p1   <= bus.req_wdata[int'(r_owner)*WORD_SIZE +: WORD_SIZE];
      end
      r_rd_valid_p2 <= r_new_req_p1 ? onehot(r_acc_idx_p1) : '0;
    end
  end

  assign bus.grant          = w_active ? onehot(r_owner) : '0;
  assign bus.in_transaction = w_active;
  assign bus.abort          = r_abort;
  assign bus.new_req        = r_new_req_p1;
  assign bus.write          = r_write_p1;
  assign bus.reg_addr       = r_addr_p1;
  assign bus.write_value    = r_wdata_p1;
  assign bus.rd_valid       = r_rd_valid_p2;
  assign bus.rdata          = bus.read_value;

endmodule
